// File: rtl/pcm_to_pdm.sv
// PCM-to-PDM transmitter: a small sample FIFO feeds a first-order sigma-delta modulator
// clocked by a divided PDM clock; every frame of SAMPLE_DEC_FACTOR bits carries exactly `sample` ones.
module pcm_to_pdm #(
   parameter int BIT_WIDTH          = 6,
   parameter int PDM_CLK_DEC_FACTOR = 12,
   parameter int SAMPLE_DEC_FACTOR  = 48,
   parameter int FIFO_DEPTH         = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic [BIT_WIDTH-1:0]        s_data,
   input  logic                        s_valid,
   output logic                        s_ready,
   output logic                        pdm_clk,
   output logic                        pdm,
   output logic                        frame_start,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        underrun
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ERR_W = BIT_WIDTH + 1;
   localparam int DIV_W = (PDM_CLK_DEC_FACTOR > 1) ? $clog2(PDM_CLK_DEC_FACTOR) : 1;
   localparam int BIT_W = (SAMPLE_DEC_FACTOR > 1) ? $clog2(SAMPLE_DEC_FACTOR) : 1;

   localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(PDM_CLK_DEC_FACTOR - 1);
   localparam logic [BIT_W-1:0]     BIT_LAST  = BIT_W'(SAMPLE_DEC_FACTOR - 1);
   localparam logic [BIT_WIDTH-1:0] CUR_MAX   = BIT_WIDTH'(SAMPLE_DEC_FACTOR);
   localparam logic [ERR_W-1:0]     ERR_FRAME = ERR_W'(SAMPLE_DEC_FACTOR);
   localparam logic [CNT_W-1:0]     CNT_FULL  = CNT_W'(FIFO_DEPTH);

   logic [BIT_WIDTH-1:0] mem [FIFO_DEPTH];

   logic [DIV_W-1:0]     div_q, div_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [ERR_W-1:0]     err_q, err_d;
   logic [BIT_WIDTH-1:0] cur_q, cur_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 pdm_clk_q, pdm_clk_d;
   logic                 pdm_q, pdm_d;
   logic                 s_ready_q, s_ready_d;
   logic                 frame_start_q, frame_start_d;
   logic                 underrun_q, underrun_d;

   logic                 push, pop, step, frame_step, div_wrap, fifo_empty;
   logic [BIT_WIDTH-1:0] head;
   logic [ERR_W-1:0]     sum;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      div_d         = div_q;
      bit_d         = bit_q;
      err_d         = err_q;
      cur_d         = cur_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      pdm_clk_d     = pdm_clk_q;
      pdm_d         = pdm_q;
      frame_start_d = 1'b0;
      underrun_d    = underrun_q;
      sum           = '0;

      push       = s_valid & s_ready_q;
      fifo_empty = (count_q == '0);
      div_wrap   = (div_q == DIV_LAST);
      step       = enable & div_wrap & pdm_clk_q;
      frame_step = step & (bit_q == '0);
      pop        = frame_step & ~fifo_empty;
      head       = mem[rd_ptr_q];

      if (enable) begin
         div_d = div_wrap ? '0 : div_q + DIV_W'(1);
         if (div_wrap) pdm_clk_d = ~pdm_clk_q;
      end else begin
         div_d     = '0;
         bit_d     = '0;
         err_d     = '0;
         pdm_clk_d = 1'b0;
         pdm_d     = 1'b0;
      end

      // The sample loaded at a frame start is already used by that frame's first step.
      if (frame_step) begin
         frame_start_d = 1'b1;
         if (fifo_empty) underrun_d = 1'b1;
         else            cur_d      = (head > CUR_MAX) ? CUR_MAX : head;
      end

      if (step) begin
         sum = err_q + {1'b0, cur_d};
         if (sum >= ERR_FRAME) begin
            pdm_d = 1'b1;
            err_d = sum - ERR_FRAME;
         end else begin
            pdm_d = 1'b0;
            err_d = sum;
         end
         bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + BIT_W'(1);
      end

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
      s_ready_d = (count_d != CNT_FULL);
   end

   always_ff @(posedge clk) begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         div_q         <= '0;
         bit_q         <= '0;
         err_q         <= '0;
         cur_q         <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         pdm_clk_q     <= 1'b0;
         pdm_q         <= 1'b0;
         s_ready_q     <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         div_q         <= div_d;
         bit_q         <= bit_d;
         err_q         <= err_d;
         cur_q         <= cur_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         pdm_clk_q     <= pdm_clk_d;
         pdm_q         <= pdm_d;
         s_ready_q     <= s_ready_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
      end
   end

   // NOTE: the sample storage has no reset; the pointers and count alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= s_data;
   end

   assign s_ready     = s_ready_q;
   assign pdm_clk     = pdm_clk_q;
   assign pdm         = pdm_q;
   assign frame_start = frame_start_q;
   assign fifo_level  = count_q;
   assign underrun    = underrun_q;

endmodule

// File: tb/tb_pcm_to_pdm.sv
// Directed bench for pcm_to_pdm: frame ones-counts recovered on pdm_clk rising edges,
// FIFO backpressure, underrun stickiness, reset and enable abort behaviour.
module tb_pcm_to_pdm;

   localparam int BW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [BW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic          pdm_clk;
   logic          pdm;
   logic          frame_start;
   logic [3:0]    fifo_level;
   logic          underrun;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pcm_to_pdm #(
      .BIT_WIDTH(BW), .PDM_CLK_DEC_FACTOR(12), .SAMPLE_DEC_FACTOR(48), .FIFO_DEPTH(8)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .pdm_clk(pdm_clk), .pdm(pdm), .frame_start(frame_start),
      .fifo_level(fifo_level), .underrun(underrun)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
      repeat (3) step();
      rst = 1'b0;
      step();
   endtask

   task automatic push(input logic [BW-1:0] v);
      bit done = 1'b0;
      s_data = v; s_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         if (s_ready) done = 1'b1;
         step();
      end
      s_valid = 1'b0;
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL push_timeout: sample %0d not accepted within 200 clk, required acceptance", v);
      end
   endtask

   task automatic wait_frame_start(output int cycles);
      cycles = -1;
      for (int i = 1; i <= 1300; i++) begin
         step();
         if (frame_start) begin cycles = i; break; end
      end
      if (cycles < 0) begin
         n_checks++; n_fail++;
         $display("FAIL frame_start_timeout: none within 1300 clk, required one");
      end
   endtask

   // Behavioural ones-counter: samples pdm on 48 consecutive pdm_clk rising edges.
   task automatic collect_frame(output int ones, output logic [47:0] bits,
                                output int cycles, output int period);
      logic prev;
      int   n = 0;
      int   first = 0;
      ones = 0; bits = '0; cycles = 0; period = 0;
      prev = pdm_clk;
      for (int i = 1; i <= 1300 && n < 48; i++) begin
         step();
         cycles = i;
         if (pdm_clk && !prev) begin
            bits[n] = pdm;
            ones += int'(pdm);
            if (n == 0) first = i;
            if (n == 1) period = i - first;
            n++;
         end
         prev = pdm_clk;
      end
      if (n < 48) begin
         n_checks++; n_fail++;
         $display("FAIL collect_timeout: got %0d pdm_clk rises, required 48", n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
      repeat (3) step();
      if (pdm_clk !== 1'b0)     begin n_fail++; $display("FAIL reset_pdm_clk: got %b expected 0", pdm_clk); end
      n_checks++;
      if (pdm !== 1'b0)         begin n_fail++; $display("FAIL reset_pdm: got %b expected 0", pdm); end
      n_checks++;
      if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
      n_checks++;
      if (underrun !== 1'b0)    begin n_fail++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
      n_checks++;
      if (fifo_level !== 4'd0)  begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
      n_checks++;
      if (s_ready !== 1'b0)     begin n_fail++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
      n_checks++;
      rst = 1'b0;
      step();
      if (s_ready !== 1'b1)     begin n_fail++; $display("FAIL post_reset_s_ready: got %b expected 1", s_ready); end
      n_checks++;
   endtask

   task automatic test_alternating();
      int ones, cc, c1, c2, period;
      logic [47:0] bits;
      do_reset();
      push(6'd24);
      enable = 1'b1;
      wait_frame_start(c1);
      if (c1 != 24) begin n_fail++; $display("FAIL alt_first_step: got %0d clk expected 24", c1); end
      n_checks++;
      step();
      if (frame_start !== 1'b0) begin n_fail++; $display("FAIL alt_pulse_width: got %b expected 0", frame_start); end
      n_checks++;
      collect_frame(ones, bits, cc, period);
      if (ones != 24) begin n_fail++; $display("FAIL alt_ones: got %0d expected 24", ones); end
      n_checks++;
      if (bits !== 48'hAAAA_AAAA_AAAA) begin n_fail++; $display("FAIL alt_pattern: got %h expected aaaaaaaaaaaa", bits); end
      n_checks++;
      if (period != 24) begin n_fail++; $display("FAIL alt_pdm_clk_period: got %0d expected 24", period); end
      n_checks++;
      wait_frame_start(c2);
      if (1 + cc + c2 != 1152) begin n_fail++; $display("FAIL alt_frame_interval: got %0d expected 1152", 1 + cc + c2); end
      n_checks++;
   endtask

   task automatic test_back_to_back();
      int ones, cc, c, period;
      logic [47:0] bits;
      int exp_ones [3] = '{0, 48, 48};
      do_reset();
      push(6'd0); push(6'd48); push(6'd63);
      enable = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_frame_start(c);
         if (k == 0) begin
            if (fifo_level !== 4'd2) begin n_fail++; $display("FAIL b2b_level: got %0d expected 2", fifo_level); end
            n_checks++;
         end
         collect_frame(ones, bits, cc, period);
         if (ones != exp_ones[k]) begin n_fail++; $display("FAIL b2b_ones[%0d]: got %0d expected %0d", k, ones, exp_ones[k]); end
         n_checks++;
      end
      if (underrun !== 1'b0) begin n_fail++; $display("FAIL b2b_underrun: got %b expected 0", underrun); end
      n_checks++;
   endtask

   task automatic test_fifo_full();
      int wait_cycles = -1;
      int ones, cc, period;
      logic [47:0] bits;
      do_reset();
      for (int i = 1; i <= 8; i++) push(BW'(i));
      if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL full_level: got %0d expected 8", fifo_level); end
      n_checks++;
      if (s_ready !== 1'b0) begin n_fail++; $display("FAIL full_s_ready: got %b expected 0", s_ready); end
      n_checks++;
      s_data = 6'd9; s_valid = 1'b1; enable = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         step();
         if (s_ready) begin wait_cycles = i; break; end
      end
      if (wait_cycles != 24) begin n_fail++; $display("FAIL full_ready_delay: got %0d clk expected 24", wait_cycles); end
      n_checks++;
      if (frame_start !== 1'b1) begin n_fail++; $display("FAIL full_pop_frame_start: got %b expected 1", frame_start); end
      n_checks++;
      if (fifo_level !== 4'd7) begin n_fail++; $display("FAIL full_after_pop: got %0d expected 7", fifo_level); end
      n_checks++;
      step();
      s_valid = 1'b0;
      if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL full_ninth_push: got %0d expected 8", fifo_level); end
      n_checks++;
      collect_frame(ones, bits, cc, period);
      if (ones != 1) begin n_fail++; $display("FAIL full_first_frame: got %0d expected 1", ones); end
      n_checks++;
   endtask

   task automatic test_underrun();
      int ones, cc, c, period;
      logic [47:0] bits;
      do_reset();
      push(6'd10);
      enable = 1'b1;
      wait_frame_start(c);
      collect_frame(ones, bits, cc, period);
      if (ones != 10) begin n_fail++; $display("FAIL ur_frame1: got %0d expected 10", ones); end
      n_checks++;
      if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_before: got %b expected 0", underrun); end
      n_checks++;
      wait_frame_start(c);
      if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_set: got %b expected 1", underrun); end
      n_checks++;
      collect_frame(ones, bits, cc, period);
      if (ones != 10) begin n_fail++; $display("FAIL ur_repeat: got %0d expected 10", ones); end
      n_checks++;
   endtask

   task automatic test_reset_midframe();
      int ones, cc, c, period, n;
      logic [47:0] bits;
      logic prev;
      do_reset();
      push(6'd48);
      enable = 1'b1;
      wait_frame_start(c);
      collect_frame(ones, bits, cc, period);
      wait_frame_start(c);
      if (underrun !== 1'b1) begin n_fail++; $display("FAIL rm_underrun_set: got %b expected 1", underrun); end
      n_checks++;
      push(6'd5);
      n = 0;
      prev = pdm_clk;
      for (int i = 0; i < 800 && n < 20; i++) begin
         step();
         if (pdm_clk && !prev) n++;
         prev = pdm_clk;
      end
      if (pdm !== 1'b1) begin n_fail++; $display("FAIL rm_pdm_before: got %b expected 1", pdm); end
      n_checks++;
      rst = 1'b1;
      step();
      if (pdm !== 1'b0)        begin n_fail++; $display("FAIL rm_pdm: got %b expected 0", pdm); end
      n_checks++;
      if (pdm_clk !== 1'b0)    begin n_fail++; $display("FAIL rm_pdm_clk: got %b expected 0", pdm_clk); end
      n_checks++;
      if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL rm_level: got %0d expected 0", fifo_level); end
      n_checks++;
      if (s_ready !== 1'b0)    begin n_fail++; $display("FAIL rm_s_ready: got %b expected 0", s_ready); end
      n_checks++;
      if (underrun !== 1'b0)   begin n_fail++; $display("FAIL rm_underrun: got %b expected 0", underrun); end
      n_checks++;
      rst = 1'b0;
      wait_frame_start(c);
      if (c != 24) begin n_fail++; $display("FAIL rm_restart: got %0d clk expected 24", c); end
      n_checks++;
      if (underrun !== 1'b1) begin n_fail++; $display("FAIL rm_first_underrun: got %b expected 1", underrun); end
      n_checks++;
      collect_frame(ones, bits, cc, period);
      if (ones != 0) begin n_fail++; $display("FAIL rm_zero_frame: got %0d expected 0", ones); end
      n_checks++;
   endtask

   task automatic test_enable_abort();
      int ones, cc, c, period, n;
      logic [47:0] bits;
      logic prev;
      do_reset();
      push(6'd24);
      enable = 1'b1;
      wait_frame_start(c);
      n = 0;
      prev = pdm_clk;
      for (int i = 0; i < 400 && n < 6; i++) begin
         step();
         if (pdm_clk && !prev) n++;
         prev = pdm_clk;
      end
      enable = 1'b0;
      step();
      if (pdm !== 1'b0 || pdm_clk !== 1'b0) begin
         n_fail++; $display("FAIL ea_idle: got pdm=%b pdm_clk=%b expected 0 0", pdm, pdm_clk);
      end
      n_checks++;
      step();
      enable = 1'b1;
      wait_frame_start(c);
      if (c != 24) begin n_fail++; $display("FAIL ea_restart: got %0d clk expected 24", c); end
      n_checks++;
      collect_frame(ones, bits, cc, period);
      if (bits !== 48'hAAAA_AAAA_AAAA) begin n_fail++; $display("FAIL ea_retained_cur: got %h expected aaaaaaaaaaaa", bits); end
      n_checks++;
   endtask

   task automatic test_sequence();
      int ones, cc, c, period;
      logic [47:0] bits;
      do_reset();
      for (int k = 1; k <= 6; k++) push(BW'(k));
      enable = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         wait_frame_start(c);
         collect_frame(ones, bits, cc, period);
         if (ones != k) begin n_fail++; $display("FAIL seq_ones[%0d]: got %0d expected %0d", k, ones, k); end
         n_checks++;
         if (k == 1) begin
            if (bits !== 48'h8000_0000_0000) begin n_fail++; $display("FAIL seq_pattern1: got %h expected 800000000000", bits); end
            n_checks++;
         end
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
      test_reset();
      test_alternating();
      test_back_to_back();
      test_fifo_full();
      test_underrun();
      test_reset_midframe();
      test_enable_abort();
      test_sequence();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
